// File: rtl/levenshtein_pkg.sv
// Shared constants for the Levenshtein pattern-match table loader.
// Build option: LEVENSHTEIN_CASE_FOLD_EN selects case-insensitive ASCII matching.
package levenshtein_pkg;

    localparam logic [4:0] REG_CTRL      = 5'h00;
    localparam logic [4:0] REG_LENGTH    = 5'h01;
    localparam logic [4:0] REG_WORD_BASE = 5'h10;

    localparam logic [9:0] PM_TABLE_BASE = 10'h200;

    localparam logic [7:0] CHAR_WORD_TERM = 8'h00;
    localparam logic [7:0] CHAR_DICT_TERM = 8'h01;
    localparam logic [7:0] CHAR_LAST      = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE_HI,
        ST_WRITE_LO
    } state_e;

    function automatic logic [7:0] fold_case(input logic [7:0] ch);
        if (ch >= 8'h41 && ch <= 8'h5A) begin
            return ch | 8'h20;
        end
        return ch;
    endfunction

endpackage

// File: rtl/levenshtein_pm_vector.sv
// Combinational match vector for one character code against the stored word.
// Build option: LEVENSHTEIN_CASE_FOLD_EN folds 'A'-'Z' onto 'a'-'z' before comparing.
module levenshtein_pm_vector
    import levenshtein_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [7:0]            char_i,
    input  logic [WIDTH-1:0][7:0] word_i,
    input  logic [3:0]            length_i,
    output logic [WIDTH-1:0]      vec_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam logic [4:0] IDX = 5'(i);
        logic in_word;
        logic match;
        assign in_word = IDX <= {1'b0, length_i};
`ifdef LEVENSHTEIN_CASE_FOLD_EN
        assign match = fold_case(word_i[i]) == fold_case(char_i);
`else
        assign match = word_i[i] == char_i;
`endif
        assign vec_o[i] = in_word & match;
    end

endmodule

// File: rtl/levenshtein_pattern_loader.sv
// Builds the 256-entry pattern-match bitvector table over a Wishbone master.
// Build option: LEVENSHTEIN_CASE_FOLD_EN enables case-insensitive matching.
module levenshtein_pattern_loader
    import levenshtein_pkg::*;
#(
    parameter int MASTER_ADDR_WIDTH = 24,
    parameter int SLAVE_ADDR_WIDTH  = 24,
    parameter int BITVECTOR_WIDTH   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         wbm_cyc_o,
    output logic                         wbm_stb_o,
    output logic                         wbm_we_o,
    output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [7:0]                   wbm_dat_o,
    input  logic                         wbm_ack_i,
    input  logic                         wbm_err_i,
    input  logic                         wbm_rty_i,
    input  logic [7:0]                   wbm_dat_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
    input  logic [7:0]                   wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic                         wbs_err_o,
    output logic                         wbs_rty_o,
    output logic [7:0]                   wbs_dat_o,
    output logic                         busy_o
);

    state_e state_q, state_d;
    logic cyc_q, cyc_d;
    logic error_q, error_d;
    logic [7:0] char_q, char_d;
    logic [3:0] length_q, length_d;
    logic [BITVECTOR_WIDTH-1:0][7:0] word_q, word_d;
    logic wbs_ack_q, wbs_ack_d;

    logic [4:0] reg_adr;
    logic wbs_req, wbs_wr, word_sel, start, busy;
    logic [BITVECTOR_WIDTH-1:0] vec;
    logic [9:0] pm_adr;
    logic unused_ok;

    assign reg_adr  = wbs_adr_i[4:0];
    assign wbs_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_q;
    assign wbs_wr   = wbs_req & wbs_we_i;
    assign word_sel = (reg_adr & 5'h10) == REG_WORD_BASE;
    assign start    = wbs_wr && (reg_adr == REG_CTRL) && wbs_dat_i[0];
    assign busy     = state_q != ST_IDLE;

    assign unused_ok = ^{wbm_dat_i, wbs_adr_i[SLAVE_ADDR_WIDTH-1:5]};

    always_comb begin
        wbs_ack_d = wbs_req;
        length_d  = length_q;
        word_d    = word_q;
        if (wbs_wr && !busy) begin
            if (reg_adr == REG_LENGTH) begin
                length_d = wbs_dat_i[3:0];
            end
            if (word_sel) begin
                word_d[reg_adr[3:0]] = wbs_dat_i;
            end
        end
    end

    always_comb begin
        wbs_dat_o = '0;
        if (reg_adr == REG_CTRL) begin
            wbs_dat_o = {6'b0, error_q, busy};
        end else if (reg_adr == REG_LENGTH) begin
            wbs_dat_o = {4'b0, length_q};
        end else if (word_sel) begin
            wbs_dat_o = word_q[reg_adr[3:0]];
        end
    end

    // cyc_q stays low on the first cycle of each write state, giving the idle gap
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        error_d = error_q;
        char_d  = char_q;
        case (state_q)
            ST_IDLE: begin
                cyc_d = 1'b0;
                if (start) begin
                    char_d  = '0;
                    error_d = 1'b0;
                    state_d = ST_WRITE_HI;
                end
            end
            ST_WRITE_HI, ST_WRITE_LO: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                end else if (wbm_err_i || wbm_rty_i) begin
                    cyc_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    if (state_q == ST_WRITE_HI) begin
                        state_d = ST_WRITE_LO;
                    end else if (char_q == CHAR_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        char_d  = char_q + 8'd1;
                        state_d = ST_WRITE_HI;
                    end
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 1'b0;
            error_q   <= 1'b0;
            char_q    <= '0;
            length_q  <= '0;
            word_q    <= '0;
            wbs_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            error_q   <= error_d;
            char_q    <= char_d;
            length_q  <= length_d;
            word_q    <= word_d;
            wbs_ack_q <= wbs_ack_d;
        end
    end

    levenshtein_pm_vector #(
        .WIDTH(BITVECTOR_WIDTH)
    ) u_pm_vector (
        .char_i  (char_q),
        .word_i  (word_q),
        .length_i(length_q),
        .vec_o   (vec)
    );

    assign pm_adr    = PM_TABLE_BASE + {1'b0, char_q, state_q == ST_WRITE_LO};
    assign wbm_adr_o = MASTER_ADDR_WIDTH'(pm_adr);
    assign wbm_dat_o = (state_q == ST_WRITE_LO) ? vec[7:0] : vec[15:8];
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;

    assign wbs_ack_o = wbs_ack_q;
    assign wbs_err_o = 1'b0;
    assign wbs_rty_o = 1'b0;
    assign busy_o    = busy;

endmodule

// File: tb/tb_levenshtein_pattern_loader.sv
// Directed self-checking bench for levenshtein_pattern_loader with a Wishbone memory model.
module tb_levenshtein_pattern_loader;
    import levenshtein_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [23:0] wbm_adr_o;
    logic [7:0]  wbm_dat_o;
    logic        m_ack, m_err;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [23:0] wbs_adr;
    logic [7:0]  wbs_dat;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic [7:0]  wbs_dat_o;
    logic        busy_o;

    logic [7:0]  mem [0:1023];
    int unsigned wr_cnt = 0;
    int unsigned err_at = 0;
    logic        err_en = 1'b0;
    logic        clr_mem = 1'b0;
    logic [9:0]  last_adr = '0;
    int unsigned prot_viol = 0;
    logic        prev_cyc = 1'b0, prev_done = 1'b0;
    logic [23:0] prev_adr = '0;
    logic [7:0]  prev_dat = '0;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    levenshtein_pattern_loader #(
        .MASTER_ADDR_WIDTH(24),
        .SLAVE_ADDR_WIDTH (24),
        .BITVECTOR_WIDTH  (16)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(m_ack),
        .wbm_err_i(m_err),
        .wbm_rty_i(1'b0),
        .wbm_dat_i(8'h00),
        .wbs_cyc_i(wbs_cyc),
        .wbs_stb_i(wbs_stb),
        .wbs_we_i (wbs_we),
        .wbs_adr_i(wbs_adr),
        .wbs_dat_i(wbs_dat),
        .wbs_ack_o(wbs_ack_o),
        .wbs_err_o(wbs_err_o),
        .wbs_rty_o(wbs_rty_o),
        .wbs_dat_o(wbs_dat_o),
        .busy_o   (busy_o)
    );

    // Memory-side slave: registered ack (or injected err) plus protocol monitor
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'hEE;
        end
        if (rst) begin
            m_ack <= 1'b0;
            m_err <= 1'b0;
        end else begin
            m_ack <= wbm_cyc_o && !m_ack && !m_err && !(err_en && wr_cnt == err_at);
            m_err <= wbm_cyc_o && !m_ack && !m_err && err_en && wr_cnt == err_at;
        end
        if (wbm_cyc_o && m_ack) begin
            mem[wbm_adr_o[9:0]] <= wbm_dat_o;
            last_adr <= wbm_adr_o[9:0];
            wr_cnt <= wr_cnt + 1;
        end
        if (wbm_cyc_o && (wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1))
            prot_viol <= prot_viol + 1;
        else if (wbm_cyc_o && prev_cyc && (wbm_adr_o != prev_adr || wbm_dat_o != prev_dat))
            prot_viol <= prot_viol + 1;
        else if (wbm_cyc_o && prev_done)
            prot_viol <= prot_viol + 1;
        prev_cyc  <= wbm_cyc_o && !rst;
        prev_done <= wbm_cyc_o && (m_ack || m_err);
        prev_adr  <= wbm_adr_o;
        prev_dat  <= wbm_dat_o;
    end

    task automatic wbs_write(input logic [4:0] a, input logic [7:0] d, output logic acked);
        @(negedge clk);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
        wbs_adr = {19'b0, a}; wbs_dat = d;
        @(posedge clk);
        @(negedge clk);
        acked = wbs_ack_o;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic wbs_read(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        wbs_adr = {19'b0, a};
        #1 d = wbs_dat_o;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_mem();
        @(negedge clk); clr_mem = 1'b1;
        @(negedge clk); clr_mem = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (wbm_cyc_o !== 1'b0) $display("FAIL reset_cyc: got %b want 0", wbm_cyc_o); else n_pass++;
        n_checks++; if (wbs_ack_o !== 1'b0) $display("FAIL reset_ack: got %b want 0", wbs_ack_o); else n_pass++;
        n_checks++; if ({wbs_err_o, wbs_rty_o} !== 2'b00) $display("FAIL reset_err_rty: got %b want 00", {wbs_err_o, wbs_rty_o}); else n_pass++;
        wbs_read(REG_CTRL, d);
        n_checks++; if (d !== 8'h00) $display("FAIL reset_ctrl: got %h want 00", d); else n_pass++;
        wbs_read(REG_LENGTH, d);
        n_checks++; if (d !== 8'h00) $display("FAIL reset_length: got %h want 00", d); else n_pass++;
        wbs_read(5'h10, d);
        n_checks++; if (d !== 8'h00) $display("FAIL reset_word0: got %h want 00", d); else n_pass++;
        wbs_read(5'h1F, d);
        n_checks++; if (d !== 8'h00) $display("FAIL reset_word15: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_basic_table();
        logic ok, ack;
        logic [7:0] d, exp_v;
        int unsigned base, bad;
        wbs_write(5'h10, 8'h61, ack);
        wbs_write(5'h11, 8'h62, ack);
        wbs_write(5'h12, 8'h63, ack);
        wbs_write(5'h13, 8'h61, ack);
        wbs_write(REG_LENGTH, 8'h03, ack);
        wbs_read(5'h12, d);
        n_checks++; if (d !== 8'h63) $display("FAIL basic_word_rd: got %h want 63", d); else n_pass++;
        wbs_read(5'h07, d);
        n_checks++; if (d !== 8'h00) $display("FAIL basic_unmapped_rd: got %h want 00", d); else n_pass++;
        clear_mem();
        base = wr_cnt;
        wbs_write(REG_CTRL, 8'h01, ack);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", busy_o); else n_pass++;
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL basic_timeout: got %b want 1", ok); else n_pass++;
        n_checks++; if (wr_cnt - base !== 512) $display("FAIL basic_count: got %0d want 512", wr_cnt - base); else n_pass++;
        n_checks++; if (mem[10'h2C2] !== 8'h00) $display("FAIL basic_a_hi: got %h want 00", mem[10'h2C2]); else n_pass++;
        n_checks++; if (mem[10'h2C3] !== 8'h09) $display("FAIL basic_a_lo: got %h want 09", mem[10'h2C3]); else n_pass++;
        n_checks++; if (mem[10'h2C5] !== 8'h02) $display("FAIL basic_b_lo: got %h want 02", mem[10'h2C5]); else n_pass++;
        n_checks++; if (mem[10'h2C7] !== 8'h04) $display("FAIL basic_c_lo: got %h want 04", mem[10'h2C7]); else n_pass++;
        n_checks++; if ({mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]} !== 32'h0)
            $display("FAIL basic_terminators: got %h%h%h%h want 00000000", mem[10'h200], mem[10'h201], mem[10'h202], mem[10'h203]);
        else n_pass++;
        bad = 0;
        for (int a = 10'h200; a < 1024; a++) begin
            exp_v = (a == 10'h2C3) ? 8'h09 : (a == 10'h2C5) ? 8'h02 : (a == 10'h2C7) ? 8'h04 : 8'h00;
            if (mem[a] !== exp_v) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL basic_others: got %0d bad entries want 0", bad); else n_pass++;
        n_checks++; if (prot_viol !== 0) $display("FAIL basic_protocol: got %0d violations want 0", prot_viol); else n_pass++;
    endtask

    task automatic test_full_length();
        logic ok, ack, seen;
        int unsigned base;
        for (int i = 0; i < 16; i++) wbs_write(5'(5'h10 + i), 8'h78, ack);
        wbs_write(REG_LENGTH, 8'h0F, ack);
        clear_mem();
        base = wr_cnt;
        wbs_write(REG_CTRL, 8'h01, ack);
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (wbm_cyc_o && m_ack && wbm_adr_o == 24'h3FF) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL full_last_ack_seen: got %b want 1", seen); else n_pass++;
        n_checks++; if (busy_o !== 1'b1) $display("FAIL full_busy_at_last_ack: got %b want 1", busy_o); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL full_busy_after_last: got %b want 0", busy_o); else n_pass++;
        wait_idle(ok);
        n_checks++; if (last_adr !== 10'h3FF) $display("FAIL full_last_adr: got %h want 3ff", last_adr); else n_pass++;
        n_checks++; if (wr_cnt - base !== 512) $display("FAIL full_count: got %0d want 512", wr_cnt - base); else n_pass++;
        n_checks++; if (mem[10'h2F0] !== 8'hFF) $display("FAIL full_x_hi: got %h want ff", mem[10'h2F0]); else n_pass++;
        n_checks++; if (mem[10'h2F1] !== 8'hFF) $display("FAIL full_x_lo: got %h want ff", mem[10'h2F1]); else n_pass++;
        n_checks++; if (mem[10'h2F3] !== 8'h00) $display("FAIL full_y_lo: got %h want 00", mem[10'h2F3]); else n_pass++;
    endtask

    task automatic test_error_abort();
        logic ok, ack, seen, cyc_seen;
        logic [7:0] d;
        int unsigned base;
        base = wr_cnt;
        err_at = base + 9;
        err_en = 1'b1;
        wbs_write(REG_CTRL, 8'h01, ack);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_err) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL err_injected: got %b want 1", seen); else n_pass++;
        @(negedge clk);
        n_checks++; if (wbm_cyc_o !== 1'b0) $display("FAIL err_cyc_drop: got %b want 0", wbm_cyc_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL err_busy: got %b want 0", busy_o); else n_pass++;
        cyc_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wbm_cyc_o) cyc_seen = 1'b1;
        end
        n_checks++; if (cyc_seen !== 1'b0) $display("FAIL err_no_more_cyc: got %b want 0", cyc_seen); else n_pass++;
        n_checks++; if (wr_cnt - base !== 9) $display("FAIL err_count: got %0d want 9", wr_cnt - base); else n_pass++;
        wbs_read(REG_CTRL, d);
        n_checks++; if (d !== 8'h02) $display("FAIL err_ctrl: got %h want 02", d); else n_pass++;
        err_en = 1'b0;
        wbs_write(REG_CTRL, 8'h01, ack);
        wbs_read(REG_CTRL, d);
        n_checks++; if (d !== 8'h01) $display("FAIL err_cleared_on_start: got %h want 01", d); else n_pass++;
        wait_idle(ok);
        wbs_read(REG_CTRL, d);
        n_checks++; if (d !== 8'h00) $display("FAIL err_ctrl_done: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_busy_writes();
        logic ok, ack;
        logic [7:0] d;
        int unsigned base;
        wbs_write(5'h10, 8'h41, ack);
        wbs_write(REG_LENGTH, 8'h00, ack);
        base = wr_cnt;
        wbs_write(REG_CTRL, 8'h01, ack);
        repeat (20) @(negedge clk);
        wbs_write(5'h10, 8'h55, ack);
        n_checks++; if (ack !== 1'b1) $display("FAIL busy_word_ack: got %b want 1", ack); else n_pass++;
        wbs_write(REG_LENGTH, 8'h07, ack);
        n_checks++; if (ack !== 1'b1) $display("FAIL busy_len_ack: got %b want 1", ack); else n_pass++;
        wbs_read(5'h10, d);
        n_checks++; if (d !== 8'h41) $display("FAIL busy_word_kept: got %h want 41", d); else n_pass++;
        wbs_read(REG_LENGTH, d);
        n_checks++; if (d !== 8'h00) $display("FAIL busy_len_kept: got %h want 00", d); else n_pass++;
        repeat (300) @(negedge clk);
        wbs_write(REG_CTRL, 8'h01, ack);
        wait_idle(ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL busy_timeout: got %b want 1", ok); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (wr_cnt - base !== 512) $display("FAIL busy_no_restart: got %0d want 512", wr_cnt - base); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL busy_stays_idle: got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_case_fold();
        logic ok, ack;
        logic [7:0] exp_a, exp_bu;
        wbs_write(5'h10, 8'h41, ack);
        wbs_write(5'h11, 8'h62, ack);
        wbs_write(REG_LENGTH, 8'h01, ack);
        clear_mem();
        wbs_write(REG_CTRL, 8'h01, ack);
        wait_idle(ok);
`ifdef LEVENSHTEIN_CASE_FOLD_EN
        exp_a = 8'h01; exp_bu = 8'h02;
`else
        exp_a = 8'h00; exp_bu = 8'h00;
`endif
        n_checks++; if (mem[10'h2C3] !== exp_a) $display("FAIL fold_a_lo: got %h want %h", mem[10'h2C3], exp_a); else n_pass++;
        n_checks++; if (mem[10'h283] !== 8'h01) $display("FAIL fold_A_lo: got %h want 01", mem[10'h283]); else n_pass++;
        n_checks++; if (mem[10'h285] !== exp_bu) $display("FAIL fold_B_lo: got %h want %h", mem[10'h285], exp_bu); else n_pass++;
        n_checks++; if (mem[10'h2C5] !== 8'h02) $display("FAIL fold_b_lo: got %h want 02", mem[10'h2C5]); else n_pass++;
    endtask

    task automatic test_reset_mid_build();
        logic ack;
        logic [7:0] d;
        wbs_write(REG_CTRL, 8'h01, ack);
        repeat (40) @(negedge clk);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy_o); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (wbm_cyc_o !== 1'b0) $display("FAIL rstmid_cyc: got %b want 0", wbm_cyc_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_o); else n_pass++;
        wbs_read(5'h10, d);
        n_checks++; if (d !== 8'h00) $display("FAIL rstmid_word0: got %h want 00", d); else n_pass++;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rstmid_stays_idle: got %b want 0", busy_o); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        wbs_adr = '0; wbs_dat = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic_table();
        test_full_length();
        test_error_abort();
        test_busy_writes();
        test_case_fold();
        test_reset_mid_build();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
